// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data memory unit.
// Optional feature macro used by the unit: DMEM_MISALIGN_TRAP_EN.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 3;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   typedef enum logic [1:0] {
      SZ_BYTE = SIZE_BYTE,
      SZ_HALF = SIZE_HALF,
      SZ_WORD = SIZE_WORD,
      SZ_RSVD = SIZE_RSVD
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Byte offset within the word after dropping the bits a halfword/word ignores.
   function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SIZE_HALF: return {off[1], 1'b0};
         SIZE_WORD: return 2'b00;
         default:   return off;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: byte enables, store-data replication and load
// extraction with zero/sign extension. Purely combinational.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       i_size,
   input  logic        i_signed,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be_c,
   output logic [31:0] o_wword_c,
   output logic [31:0] o_rdata_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lowest address maps to the most significant lane.
   always_comb begin
      o_be_c    = 4'b0000;
      o_wword_c = 32'h0;
      o_rdata_c = 32'h0;
      case (i_off)
         2'd0:    w_byte = i_rword[31:24];
         2'd1:    w_byte = i_rword[23:16];
         2'd2:    w_byte = i_rword[15:8];
         default: w_byte = i_rword[7:0];
      endcase
      w_half = i_off[1] ? i_rword[15:0] : i_rword[31:16];
      case (i_size)
         SZ_BYTE: begin
            o_be_c    = 4'b1000 >> i_off;
            o_wword_c = {4{i_wdata[7:0]}};
            o_rdata_c = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_be_c    = i_off[1] ? 4'b0011 : 4'b1100;
            o_wword_c = {2{i_wdata[15:0]}};
            o_rdata_c = {{16{i_signed & w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            o_be_c    = 4'b1111;
            o_wword_c = i_wdata;
            o_rdata_c = i_rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_mem_unit.sv
// Single-outstanding, fixed-latency, byte-addressed big-endian data memory.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned     IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH_WORDS * 4);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              w_cap;
   logic              r_we, r_signed, r_err;
   size_e             r_size;
   logic [IDX_W-1:0]  r_idx;
   logic [1:0]        r_off;
   logic [31:0]       r_wdata;
   logic              r_req_ready, w_req_ready_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic              r_rsp_err, w_rsp_err_nxt;
   logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;

   logic              w_oor, w_size_bad, w_mis, w_req_err;
   logic [1:0]        w_req_off;
   logic [31:0]       w_rword, w_wword, w_rdata;
   logic [3:0]        w_be;
   logic              w_commit;

   logic [31:0] r_mem [DEPTH_WORDS] = '{default: 32'h0};

   assign w_oor      = ({1'b0, req_addr} >= MEM_BYTES);
   assign w_size_bad = (req_size == SIZE_RSVD);
   assign w_req_off  = align_off(req_size, req_addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = ((req_size == SIZE_HALF) && req_addr[0]) ||
                  ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif
   assign w_req_err = w_oor | w_size_bad | w_mis;

   assign w_rword = r_mem[r_idx];

   dmem_lane_align u_lane (
      .i_size    (r_size),
      .i_signed  (r_signed),
      .i_off     (r_off),
      .i_wdata   (r_wdata),
      .i_rword   (w_rword),
      .o_be_c    (w_be),
      .o_wword_c (w_wword),
      .o_rdata_c (w_rdata)
   );

   // Stores land on the WAIT->RESP edge; a reset in flight cancels them.
   assign w_commit = (r_state == ST_WAIT) && (r_cnt == '0) && r_we && !r_err && !rst;

   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[r_idx][8*b +: 8] <= w_wword[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= 32'h0;
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_err       <= 1'b0;
         r_size      <= SZ_BYTE;
         r_idx       <= '0;
         r_off       <= 2'b00;
         r_wdata     <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         if (w_cap) begin
            r_we     <= req_we;
            r_signed <= req_signed;
            r_err    <= w_req_err;
            r_size   <= size_e'(req_size);
            r_idx    <= req_addr[IDX_W+1:2];
            r_off    <= w_req_off;
            r_wdata  <= req_wdata;
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_cap           = 1'b0;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_err_nxt   = r_rsp_err;
      w_rsp_rdata_nxt = r_rsp_rdata;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = CNT_LOAD;
               w_cap       = 1'b1;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt     = ST_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = r_err;
               w_rsp_rdata_nxt = (r_err || r_we) ? 32'h0 : w_rdata;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = ST_IDLE;
               w_rsp_valid_nxt = 1'b0;
               w_rsp_err_nxt   = 1'b0;
               w_rsp_rdata_nxt = 32'h0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_req_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have parameter LATENCY, default 1, range 1..8, meaning wait cycles between request accept and response.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-010 req_signed  in  1  sign-extend byte/halfword loads.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  32  store data, right-justified.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-016 rsp_err  out  1  access faulted.

Function
REQ-017 Storage SHALL be byte-addressed, big-endian: byte at address A is bits [31:24] of the word at A & ~3.
REQ-018 FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE->WAIT on req_valid; request fields are captured on that edge, and the wait counter loads LATENCY-1.
REQ-020 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0; accept-to-rsp_valid latency is exactly LATENCY+1 cycles.
REQ-021 A store SHALL commit on the WAIT->RESP edge, writing only the addressed bytes; other bytes are unchanged.
REQ-022 Load data SHALL be sampled on the WAIT->RESP edge and held stable in RESP.
REQ-023 In RESP, rsp_valid = 1; RESP->IDLE on rsp_ready; rsp_valid, rsp_rdata and rsp_err are held while rsp_ready = 0.
REQ-024 Byte/halfword loads SHALL zero-extend when req_signed = 0 and sign-extend when req_signed = 1; word loads ignore req_signed.
REQ-025 A request with req_size = 3 or byte address >= DEPTH_WORDS*4 SHALL set rsp_err = 1, perform no write, and return rdata 0.
REQ-026 The unit SHALL allow only one outstanding request; no new request is accepted in the cycle rsp_ready completes a response.
REQ-027 Memory contents SHALL initialise to zero at time 0.

Reset
REQ-028 rst SHALL force the state to IDLE and clear rsp_valid, rsp_err, rsp_rdata and the counter to 0 immediately.
REQ-029 rst SHALL NOT clear memory contents.
REQ-030 rst during WAIT SHALL drop the request, and a pending store SHALL not commit.

Configuration
REQ-031 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0] != 0, or a word access with addr[1:0] != 0, SHALL return rsp_err = 1 with no write.
REQ-032 Without DMEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be silently aligned down (halfword: addr[0] cleared; word: addr[1:0] cleared), with no error.

Structure
REQ-033 Package dmem_pkg SHALL hold the access-size enum, the FSM state enum and the size encodings.
REQ-034 Sub-module dmem_lane_align (combinational) SHALL perform byte-enable generation, store-data lane placement and load extraction/extension.

Verification
REQ-035 LATENCY = 1: store word 0x11223344 @0x10, then load word @0x10 -> rdata 0x11223344, rsp_valid 2 cycles after accept.
REQ-036 Store byte 0xAB @0x11 over 0x11223344, then load word @0x10 -> 0x11AB3344; signed byte load @0x11 -> 0xFFFFFFAB; unsigned byte load @0x11 -> 0x000000AB.
REQ-037 LATENCY = 4, rsp_ready held low 3 cycles -> rsp_valid held, rdata stable, req_ready = 0 throughout.
REQ-038 Load word @DEPTH_WORDS*4 -> rsp_err = 1, rdata 0; store with req_size = 3 -> rsp_err = 1, memory unchanged.
REQ-039 Store word @0x20 with rst asserted during WAIT -> outputs 0 immediately; later load @0x20 -> 0x00000000.
REQ-040 Load word @0x12: with DMEM_MISALIGN_TRAP_EN -> rsp_err = 1; without it -> returns the word at 0x10.
